// File: rtl/el2_exu_noc_multi_sender.sv
// el2_exu_noc_multi_sender: multi-channel buffered NoC injector.
// Each producer channel has its own FIFO. A round-robin arbiter picks a channel,
// and the head packet is sent LSB-first as FLIT_BITS-wide flits on the up port.
// Optional feature macro: EL2_NOC_FLIT_PARITY_EN adds the up_parity output.
module el2_exu_noc_multi_sender #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned PACKET_BITS = 65,
    parameter int unsigned FLIT_BITS   = 32,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned ADDR_BITS   = 4,
    parameter logic [NUM_CH*ADDR_BITS-1:0] DST_ADDR = '0
) (
    input  logic                          clk_noc,
    input  logic                          rst_l,
    input  logic                          flush,
    input  logic [NUM_CH-1:0]             ch_valid,
    input  logic [NUM_CH*PACKET_BITS-1:0] ch_packet,
    output logic [NUM_CH-1:0]             ch_ready,
    output logic [NUM_CH-1:0]             ch_overflow,
    output logic                          up_valid,
    input  logic                          up_ready,
    output logic [FLIT_BITS-1:0]          up_flit,
    output logic [ADDR_BITS-1:0]          up_dst,
    output logic                          up_head,
    output logic                          up_tail,
`ifdef EL2_NOC_FLIT_PARITY_EN
    output logic                          up_parity,
`endif
    output logic                          busy
);

    localparam int unsigned FLITS = (PACKET_BITS + FLIT_BITS - 1) / FLIT_BITS;
    localparam int unsigned SR_W  = FLITS * FLIT_BITS;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (FLITS > 1) ? $clog2(FLITS) : 1;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                 state_q;
    logic [CH_W-1:0]        grant_q;
    logic [CH_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]       idx_q;
    logic [SR_W-1:0]        sr_q;
    logic [ADDR_BITS-1:0]   dst_q;
    logic [NUM_CH-1:0]      overflow_q;

    logic [PACKET_BITS-1:0] mem_q    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]       rd_ptr_q [NUM_CH];
    logic [CNT_W-1:0]       count_q  [NUM_CH];

    logic [NUM_CH-1:0]      push;
    logic [NUM_CH-1:0]      pop;
    logic                   send;
    logic                   pop_fire;
    logic                   arb_found;
    logic [CH_W-1:0]        arb_gnt;
    logic [PACKET_BITS-1:0] head_pkt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Up-port outputs are decoded from registered state only.
    assign send     = (state_q == StSend);
    assign up_valid = send;
    assign up_flit  = sr_q[FLIT_BITS-1:0];
    assign up_dst   = dst_q;
    assign up_head  = send && (idx_q == '0);
    assign up_tail  = send && (idx_q == IDX_W'(FLITS - 1));
    assign pop_fire = send && up_ready && up_tail;
    assign ch_overflow = overflow_q;
    assign head_pkt = mem_q[arb_gnt][rd_ptr_q[arb_gnt]];

`ifdef EL2_NOC_FLIT_PARITY_EN
    // Parity is a pure function of the registered flit fields, so it moves with them.
    assign up_parity = ^{up_dst, up_head, up_tail, up_flit};
`endif

    // Per-channel ready/push/pop and aggregate busy.
    always_comb begin
        busy = send;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ready[i] = (count_q[i] != CNT_W'(DEPTH));
            push[i]     = ch_valid[i] && ch_ready[i] && !flush;
            pop[i]      = pop_fire && (grant_q == CH_W'(i));
            if (count_q[i] != '0) busy = 1'b1;
        end
    end

    // Round-robin search: first non-empty channel at or above rr_ptr, with wrap.
    always_comb begin
        int unsigned c;
        c         = 0;
        arb_found = 1'b0;
        arb_gnt   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (int'(rr_ptr_q) + k) % NUM_CH;
            if (!arb_found && (count_q[c] != '0)) begin
                arb_found = 1'b1;
                arb_gnt   = CH_W'(c);
            end
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_noc) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= ch_packet[i*PACKET_BITS +: PACKET_BITS];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flags.
    always_ff @(posedge clk_noc or negedge rst_l) begin
        if (!rst_l) begin
            overflow_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else if (flush) begin
            overflow_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
                if (pop[i])  rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
                if (push[i] && !pop[i])      count_q[i] <= count_q[i] + 1'b1;
                else if (pop[i] && !push[i]) count_q[i] <= count_q[i] - 1'b1;
                if (ch_valid[i] && !ch_ready[i]) overflow_q[i] <= 1'b1;
            end
        end
    end

    // Grant/serialise FSM; the FIFO entry stays until its tail flit is accepted.
    always_ff @(posedge clk_noc or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            sr_q     <= '0;
            dst_q    <= '0;
        end else if (flush) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_found) begin
                        grant_q <= arb_gnt;
                        sr_q    <= SR_W'(head_pkt);
                        dst_q   <= DST_ADDR[arb_gnt*ADDR_BITS +: ADDR_BITS];
                        idx_q   <= '0;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (up_ready) begin
                        if (up_tail) begin
                            state_q  <= StIdle;
                            rr_ptr_q <= (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
                        end else begin
                            sr_q  <= sr_q >> FLIT_BITS;
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_el2_exu_noc_multi_sender.sv
// Directed self-checking bench for el2_exu_noc_multi_sender (default sizes, DST 5/9).
module tb_el2_exu_noc_multi_sender;

    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned PACKET_BITS = 65;
    localparam int unsigned FLIT_BITS   = 32;
    localparam int unsigned DEPTH       = 2;
    localparam int unsigned ADDR_BITS   = 4;
    localparam logic [7:0]  DST         = 8'h95;

    logic                          clk_noc = 1'b0;
    logic                          rst_l;
    logic                          flush;
    logic [NUM_CH-1:0]             ch_valid;
    logic [NUM_CH*PACKET_BITS-1:0] ch_packet;
    logic [NUM_CH-1:0]             ch_ready;
    logic [NUM_CH-1:0]             ch_overflow;
    logic                          up_valid;
    logic                          up_ready;
    logic [FLIT_BITS-1:0]          up_flit;
    logic [ADDR_BITS-1:0]          up_dst;
    logic                          up_head;
    logic                          up_tail;
`ifdef EL2_NOC_FLIT_PARITY_EN
    logic                          up_parity;
`endif
    logic                          busy;

    int checks   = 0;
    int failures = 0;
    logic [35:0] mon_q[$];

    el2_exu_noc_multi_sender #(
        .NUM_CH     (NUM_CH),
        .PACKET_BITS(PACKET_BITS),
        .FLIT_BITS  (FLIT_BITS),
        .DEPTH      (DEPTH),
        .ADDR_BITS  (ADDR_BITS),
        .DST_ADDR   (DST)
    ) dut (
        .clk_noc    (clk_noc),
        .rst_l      (rst_l),
        .flush      (flush),
        .ch_valid   (ch_valid),
        .ch_packet  (ch_packet),
        .ch_ready   (ch_ready),
        .ch_overflow(ch_overflow),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_flit    (up_flit),
        .up_dst     (up_dst),
        .up_head    (up_head),
        .up_tail    (up_tail),
`ifdef EL2_NOC_FLIT_PARITY_EN
        .up_parity  (up_parity),
`endif
        .busy       (busy)
    );

    always #5 clk_noc = ~clk_noc;

    // Record {dst, first flit} of every accepted head flit.
    always @(negedge clk_noc) begin
        if (rst_l && up_valid && up_ready && up_head) mon_q.push_back({up_dst, up_flit});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic cyc;
        @(posedge clk_noc);
        #1;
    endtask

    task automatic set_pkt(input int ch, input logic [64:0] p);
        ch_packet[ch*PACKET_BITS +: PACKET_BITS] = p;
    endtask

    task automatic do_reset;
        ch_valid = '0;
        flush    = 1'b0;
        up_ready = 1'b1;
        cyc;
        rst_l = 1'b0;
        cyc;
        rst_l = 1'b1;
        cyc;
    endtask

    task automatic test_reset;
        rst_l = 1'b0;
        #2;
        checks++;
        if ({up_valid, up_head, up_tail, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctl: got %b want 0000", {up_valid, up_head, up_tail, busy});
        end
        checks++;
        if ({up_dst, up_flit} !== 36'h0) begin
            failures++;
            $display("FAIL reset_data: got %h want 0", {up_dst, up_flit});
        end
        checks++;
        if ({ch_ready, ch_overflow} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_ch: got %b want 1100", {ch_ready, ch_overflow});
        end
        cyc;
        rst_l = 1'b1;
        cyc;
        cyc;
        checks++;
        if ({up_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle: got %b want 00", {up_valid, busy});
        end
    endtask

    task automatic test_single;
        up_ready = 1'b1;
        set_pkt(0, 65'h1_DEADBEEF_CAFEF00D);
        ch_valid = 2'b01;
        cyc;
        ch_valid = 2'b00;
        checks++;
        if ({up_valid, busy} !== 2'b01) begin
            failures++;
            $display("FAIL single_t1: got %b want 01", {up_valid, busy});
        end
        cyc;
        checks++;
        if ({up_valid, up_head, up_tail, up_dst, up_flit} !== {3'b110, 4'h5, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL single_flit0: got %h want %h", {up_valid, up_head, up_tail, up_dst, up_flit},
                     {3'b110, 4'h5, 32'hCAFEF00D});
        end
`ifdef EL2_NOC_FLIT_PARITY_EN
        checks++;
        if (up_parity !== ^{4'h5, 1'b1, 1'b0, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL parity_f0: got %b want %b", up_parity, ^{4'h5, 1'b1, 1'b0, 32'hCAFEF00D});
        end
`endif
        cyc;
        checks++;
        if ({up_valid, up_head, up_tail, up_dst, up_flit} !== {3'b100, 4'h5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL single_flit1: got %h want %h", {up_valid, up_head, up_tail, up_dst, up_flit},
                     {3'b100, 4'h5, 32'hDEADBEEF});
        end
`ifdef EL2_NOC_FLIT_PARITY_EN
        checks++;
        if (up_parity !== ^{4'h5, 1'b0, 1'b0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL parity_f1: got %b want %b", up_parity, ^{4'h5, 1'b0, 1'b0, 32'hDEADBEEF});
        end
`endif
        cyc;
        checks++;
        if ({up_valid, up_head, up_tail, up_dst, up_flit} !== {3'b101, 4'h5, 32'h00000001}) begin
            failures++;
            $display("FAIL single_flit2: got %h want %h", {up_valid, up_head, up_tail, up_dst, up_flit},
                     {3'b101, 4'h5, 32'h00000001});
        end
`ifdef EL2_NOC_FLIT_PARITY_EN
        checks++;
        if (up_parity !== ^{4'h5, 1'b0, 1'b1, 32'h00000001}) begin
            failures++;
            $display("FAIL parity_f2: got %b want %b", up_parity, ^{4'h5, 1'b0, 1'b1, 32'h00000001});
        end
`endif
        cyc;
        checks++;
        if ({up_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL single_after: got %b want 00", {up_valid, busy});
        end
    endtask

    task automatic test_round_robin;
        int base;
        int n;
        logic [35:0] got;
        logic [35:0] exp [6];
        exp = '{{4'h5, 32'hA0000001}, {4'h9, 32'hB0000001}, {4'h5, 32'hA0000002},
                {4'h9, 32'hB0000002}, {4'h5, 32'hA0000003}, {4'h9, 32'hB0000003}};
        base = mon_q.size();
        set_pkt(0, 65'hA0000001);
        set_pkt(1, 65'hB0000001);
        ch_valid = 2'b11;
        cyc;
        set_pkt(0, 65'hA0000002);
        set_pkt(1, 65'hB0000002);
        cyc;
        ch_valid = 2'b00;
        n = 0;
        while (ch_ready !== 2'b11 && n < 30) begin
            cyc;
            n++;
        end
        checks++;
        if (ch_ready !== 2'b11) begin
            failures++;
            $display("FAIL rr_space: got %b want 11", ch_ready);
        end
        set_pkt(0, 65'hA0000003);
        set_pkt(1, 65'hB0000003);
        ch_valid = 2'b11;
        cyc;
        ch_valid = 2'b00;
        repeat (24) cyc;
        checks++;
        if (mon_q.size() - base != 6) begin
            failures++;
            $display("FAIL rr_count: got %0d want 6", mon_q.size() - base);
        end
        for (int k = 0; k < 6; k++) begin
            got = (base + k < mon_q.size()) ? mon_q[base + k] : 36'hx;
            checks++;
            if (got !== exp[k]) begin
                failures++;
                $display("FAIL rr_order[%0d]: got %h want %h", k, got, exp[k]);
            end
        end
    endtask

    task automatic test_backpressure;
        int base;
        logic [35:0] got;
        base = mon_q.size();
        set_pkt(0, 65'h0_11111111_22222222);
        ch_valid = 2'b01;
        cyc;
        set_pkt(0, 65'h0_33333333_44444444);
        cyc;
        checks++;
        if ({ch_ready[0], ch_overflow} !== 3'b000) begin
            failures++;
            $display("FAIL bp_full: got %b want 000", {ch_ready[0], ch_overflow});
        end
        set_pkt(0, 65'h0_EEEEEEEE_EEEEEEEE);
        cyc;
        ch_valid = 2'b00;
        checks++;
        if (ch_overflow !== 2'b01) begin
            failures++;
            $display("FAIL bp_overflow: got %b want 01", ch_overflow);
        end
        up_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc;
            checks++;
            if ({up_valid, up_head, up_tail, up_dst, up_flit} !== {3'b100, 4'h5, 32'h11111111}) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got %h want %h", k,
                         {up_valid, up_head, up_tail, up_dst, up_flit}, {3'b100, 4'h5, 32'h11111111});
            end
        end
        up_ready = 1'b1;
        repeat (12) cyc;
        checks++;
        if (mon_q.size() - base != 2) begin
            failures++;
            $display("FAIL bp_count: got %0d want 2", mon_q.size() - base);
        end
        got = (base + 1 < mon_q.size()) ? mon_q[base + 1] : 36'hx;
        checks++;
        if (got !== {4'h5, 32'h44444444}) begin
            failures++;
            $display("FAIL bp_second: got %h want %h", got, {4'h5, 32'h44444444});
        end
    endtask

    task automatic test_flush;
        int base;
        logic saw;
        base = mon_q.size();
        set_pkt(0, 65'h0_55555555_66666666);
        ch_valid = 2'b01;
        cyc;
        set_pkt(1, 65'h0_77777777_88888888);
        ch_valid = 2'b10;
        cyc;
        ch_valid = 2'b00;
        cyc;
        checks++;
        if ({up_valid, up_flit} !== {1'b1, 32'h55555555}) begin
            failures++;
            $display("FAIL flush_pre: got %h want %h", {up_valid, up_flit}, {1'b1, 32'h55555555});
        end
        flush = 1'b1;
        set_pkt(1, 65'h0_99999999_99999999);
        ch_valid = 2'b10;
        cyc;
        flush    = 1'b0;
        ch_valid = 2'b00;
        checks++;
        if ({up_valid, busy, ch_ready, ch_overflow} !== 6'b001100) begin
            failures++;
            $display("FAIL flush_state: got %b want 001100", {up_valid, busy, ch_ready, ch_overflow});
        end
        saw = 1'b0;
        repeat (10) begin
            cyc;
            if (up_valid) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || mon_q.size() - base != 1) begin
            failures++;
            $display("FAIL flush_quiet: got valid_seen=%b heads=%0d want 0 1", saw, mon_q.size() - base);
        end
    endtask

    task automatic test_async_reset;
        set_pkt(1, 65'h1_ABCDEF01_23456789);
        ch_valid = 2'b10;
        cyc;
        cyc;
        cyc;
        ch_valid = 2'b00;
        checks++;
        if ({up_valid, up_dst, up_flit, ch_overflow} !== {1'b1, 4'h9, 32'hABCDEF01, 2'b10}) begin
            failures++;
            $display("FAIL arst_pre: got %h want %h", {up_valid, up_dst, up_flit, ch_overflow},
                     {1'b1, 4'h9, 32'hABCDEF01, 2'b10});
        end
        #2;
        rst_l = 1'b0;
        #1;
        checks++;
        if ({up_valid, up_head, up_tail, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL arst_ctl: got %b want 0000", {up_valid, up_head, up_tail, busy});
        end
        checks++;
        if ({up_dst, up_flit, ch_ready, ch_overflow} !== {36'h0, 4'b1100}) begin
            failures++;
            $display("FAIL arst_data: got %h want %h", {up_dst, up_flit, ch_ready, ch_overflow},
                     {36'h0, 4'b1100});
        end
`ifdef EL2_NOC_FLIT_PARITY_EN
        checks++;
        if (up_parity !== 1'b0) begin
            failures++;
            $display("FAIL arst_parity: got %b want 0", up_parity);
        end
`endif
        cyc;
        rst_l = 1'b1;
        cyc;
    endtask

    initial begin
        rst_l     = 1'b0;
        flush     = 1'b0;
        ch_valid  = '0;
        ch_packet = '0;
        up_ready  = 1'b1;
        test_reset();
        test_single();
        do_reset();
        test_round_robin();
        do_reset();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
